inst_fetch_unit: RTL

- Instruction-fetch initiator for the DLX core: owns the fetch PC and drives word addresses into the combinational instruction ROM.
- Captures each returned 32-bit word into a small prefetch FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Supports branch/jump redirects, which flush the FIFO.

---
 rtl/dlx_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/inst_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the DLX instruction-fetch path.
package dlx_fetch_pkg;

  localparam int unsigned INST_W = 32;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_e;

  localparam logic [INST_W-1:0] NOP = 32'h0;

  // Entry layout at the default 32-bit PC; the FIFO stores {pc, inst} packed the same way.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry prefetch FIFO with a registered head word.
module fetch_fifo #(
  parameter  int unsigned W     = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] cnt_next;
  logic [W-1:0]     head_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // The head is registered from next-cycle state, so an entry written this
  // cycle that lands at the new read slot is forwarded straight from din.
  always_comb begin
    rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_next  = count;
    if (push && !pop) begin
      cnt_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_next = count - CNT_W'(1);
    end
    head_next = (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count <= cnt_next;
      if (cnt_next != '0) begin
        head <= head_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// DLX instruction-fetch initiator: fetch PC, ROM addressing, prefetch FIFO, redirects.
// Optional build macro FETCH_HALT_EN stops fetching after END_PC.
module inst_fetch_unit
  import dlx_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned END_PC   = 31
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              halted_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;

  assign rom_addr_o   = fetch_pc_q;
  assign inst_valid_o = (fifo_count != '0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign push         = (state_q == FETCH) & ~redirect_i & (~fifo_full | pop);
  assign {pc_o, inst_o} = fifo_head;

  // HALTED is never entered without FETCH_HALT_EN, so this reduces to 0 there.
  assign halted_o = (state_q == HALTED) & fifo_empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= FETCH;
      fetch_pc_q <= ADDR_W'(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc_i;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
`ifdef FETCH_HALT_EN
      if (32'(fetch_pc_q) == END_PC) begin
        state_d = HALTED;
      end
`endif
    end
  end

  fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_i),
    .din     ({fetch_pc_q, rom_data_i}),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
